// File: rtl/cordic_quadrant_wrap.sv
// Angle range reduction front end for a CORDIC sin/cos core.
// Ports: clock/reset, angle in (valid/ready), core start/ready/angle/sin/cos, sin/cos out (valid/ready).
module cordic_quadrant_wrap #(
   parameter int W_IN    = 13,
   parameter int W       = 12,
   parameter int PI_FXP  = 3217,
   parameter int HPI_FXP = 1608
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W_IN-1:0]     angle_in,
   output logic                core_start,
   output logic [W-1:0]        core_angle,
   input  logic                core_ready,
   input  logic [W-1:0]        core_sin,
   input  logic [W-1:0]        core_cos,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        sin_out,
   output logic [W-1:0]        cos_out
);

   localparam int WA = W_IN + 1;

   localparam logic signed [WA-1:0] PI_A  = WA'(PI_FXP);
   localparam logic signed [WA-1:0] HPI_A = WA'(HPI_FXP);
   localparam logic signed [WA-1:0] PI2_A = WA'(2 * PI_FXP);

   localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [2:0] {
      IDLE,
      WRAP,
      FOLD,
      ACK,
      DONE,
      OUT
   } state_t;

   state_t state;
   state_t state_nx;

   logic signed [WA-1:0] a_q;
   logic signed [WA-1:0] wrapped;
   logic signed [WA-1:0] folded;
   logic                 fold_neg;
   logic                 neg_cos;
   logic signed [W-1:0]  cos_in;
   logic signed [W-1:0]  cos_fix;

   // in_ready is forced low while reset is held even though state is IDLE
   assign in_ready = (state == IDLE) && reset;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = WRAP;
         WRAP: state_nx = FOLD;
         FOLD: state_nx = ACK;
         ACK:  if (!core_ready) state_nx = DONE;
         DONE: if (core_ready) state_nx = OUT;
         OUT:  if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // bring the angle into [-pi, pi]
   always_comb begin
      wrapped = a_q;
      if (a_q > PI_A) begin
         wrapped = a_q - PI2_A;
      end else if (a_q < -PI_A) begin
         wrapped = a_q + PI2_A;
      end
   end

   // mirror about +/-pi/2: sin is preserved, cos changes sign
   always_comb begin
      folded   = a_q;
      fold_neg = 1'b0;
      if (a_q > HPI_A) begin
         folded   = PI_A - a_q;
         fold_neg = 1'b1;
      end else if (a_q < -HPI_A) begin
         folded   = -PI_A - a_q;
         fold_neg = 1'b1;
      end
   end

   // -(-2048) does not fit, clamp to +2047
   always_comb begin
      cos_in  = $signed(core_cos);
      cos_fix = cos_in;
      if (neg_cos) begin
         cos_fix = (cos_in == S_MIN) ? S_MAX : -cos_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_q        <= '0;
         core_start <= 1'b0;
         core_angle <= '0;
         neg_cos    <= 1'b0;
         out_valid  <= 1'b0;
         sin_out    <= '0;
         cos_out    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q <= WA'($signed(angle_in));
               end
            end
            WRAP: begin
               a_q <= wrapped;
            end
            FOLD: begin
               core_angle <= folded[W-1:0];
               neg_cos    <= fold_neg;
               core_start <= 1'b1;
            end
            ACK: begin
            end
            DONE: begin
               if (core_ready) begin
                  sin_out    <= core_sin;
                  cos_out    <= cos_fix;
                  core_start <= 1'b0;
                  out_valid  <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
